// File: rtl/pe_ws_mbank.sv
// pe_ws_mbank: weight-stationary systolic processing element with NUM_BANKS
// weight registers organised as a circular queue. One bank is active and feeds
// the MAC while the remaining shadow banks preload the next tile's weights.
// A w_swap pulse advances the active bank to the oldest loaded shadow bank with
// no pipeline bubble.
//
// Parameters:
//   D_W       activation/weight width
//   ACC_W     partial-sum width (>= 2*D_W)
//   NUM_BANKS weight banks (>= 2, power of two)
//
// Ports:
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   signed_mode                   1: operands two's complement, 0: unsigned
//   in_act / in_act_vld           activation from west
//   in_weight / in_weight_vld     weight from north; valid loads next shadow bank
//   w_swap                        advance active bank to oldest loaded shadow
//   in_sum                        partial sum from north
//   out_act / out_act_vld         registered activation to east
//   out_weight / out_weight_vld   registered weight to south
//   out_sum / out_sum_vld         registered partial sum to south
//   w_pending                     loaded shadow banks not yet active
//   err                           sticky: load while full or swap while empty
//
// Build option:
//   PE_SAT_EN  when defined the accumulate saturates instead of wrapping.
module pe_ws_mbank #(
  parameter int D_W       = 8,
  parameter int ACC_W     = 20,
  parameter int NUM_BANKS = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             signed_mode,
  input  logic [D_W-1:0]                   in_act,
  input  logic                             in_act_vld,
  input  logic [D_W-1:0]                   in_weight,
  input  logic                             in_weight_vld,
  input  logic                             w_swap,
  input  logic [ACC_W-1:0]                 in_sum,
  output logic [D_W-1:0]                   out_act,
  output logic                             out_act_vld,
  output logic [D_W-1:0]                   out_weight,
  output logic                             out_weight_vld,
  output logic [ACC_W-1:0]                 out_sum,
  output logic                             out_sum_vld,
  output logic [2+$clog2(NUM_BANKS)-1:0]   w_pending,
  output logic                             err
);

  localparam int AW = $clog2(NUM_BANKS);
  localparam int PW = 2 + $clog2(NUM_BANKS);
  localparam int PF = 2 * D_W + 2;
  localparam logic [PW-1:0] PEND_MAX = PW'(NUM_BANKS - 1);

  // Weight bank queue state. wr_ptr_q marks the most recently loaded slot, so
  // the invariant wr_ptr_q == act_ptr_q + pend_q (mod NUM_BANKS) always holds
  // and the next load goes to wr_ptr_q + 1, never the active bank.
  logic [D_W-1:0]   bank_q [NUM_BANKS];
  logic [D_W-1:0]   bank_d [NUM_BANKS];
  logic [AW-1:0]    act_ptr_q, act_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    wr_addr;
  logic [PW-1:0]    pend_q, pend_d;
  logic             err_q, err_d;

  logic             load_ok, load_drop, swap_ok, swap_bad;

  logic [D_W-1:0]   out_act_q, out_act_d;
  logic             out_act_vld_q, out_act_vld_d;
  logic [D_W-1:0]   out_weight_q, out_weight_d;
  logic             out_weight_vld_q, out_weight_vld_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_sum_vld_q, out_sum_vld_d;

  // MAC datapath
  logic [D_W-1:0]        w_act;
  logic signed [D_W:0]   act_x, w_x;
  logic signed [PF-1:0]  prod_full;
  logic [ACC_W-1:0]      prod_acc;
  logic [ACC_W-1:0]      sum_wrap;
  logic [ACC_W-1:0]      sum_mac;
`ifdef PE_SAT_EN
  logic [ACC_W:0]        sum_ext;
  logic                  ovf_s;
  logic                  ovf_u;
`endif

  // Bank queue control: load/swap decisions use the pre-edge pending count.
  always_comb begin
    load_ok   = in_weight_vld && (pend_q < PEND_MAX);
    load_drop = in_weight_vld && !(pend_q < PEND_MAX);
    swap_ok   = w_swap && (pend_q != {PW{1'b0}});
    swap_bad  = w_swap && (pend_q == {PW{1'b0}});
    wr_addr   = wr_ptr_q + AW'(1);

    bank_d    = bank_q;
    wr_ptr_d  = wr_ptr_q;
    if (load_ok) begin
      bank_d[wr_addr] = in_weight;
      wr_ptr_d        = wr_addr;
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end

    if (swap_ok) begin
      act_ptr_d = act_ptr_q + AW'(1);
    end else begin
      act_ptr_d = act_ptr_q;
    end

    case ({load_ok, swap_ok})
      2'b10:   pend_d = pend_q + PW'(1);
      2'b01:   pend_d = pend_q - PW'(1);
      default: pend_d = pend_q;
    endcase

    err_d = err_q | load_drop | swap_bad;
  end

  // MAC: product uses the active bank as it was before this edge, so a swap
  // cycle still multiplies by the outgoing weight.
  always_comb begin
    w_act     = bank_q[act_ptr_q];
    act_x     = {signed_mode & in_act[D_W-1], in_act};
    w_x       = {signed_mode & w_act[D_W-1], w_act};
    prod_full = act_x * w_x;
    // Size cast of a signed value sign-extends; unsigned operands were
    // zero-extended above so the product is already non-negative.
    prod_acc  = ACC_W'(prod_full);
`ifdef PE_SAT_EN
    sum_ext  = {1'b0, in_sum} + {1'b0, prod_acc};
    sum_wrap = sum_ext[ACC_W-1:0];
    ovf_s    = (in_sum[ACC_W-1] == prod_acc[ACC_W-1]) &&
               (sum_wrap[ACC_W-1] != in_sum[ACC_W-1]);
    ovf_u    = sum_ext[ACC_W];
    if (signed_mode) begin
      if (ovf_s) begin
        sum_mac = in_sum[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        sum_mac = sum_wrap;
      end
    end else begin
      if (ovf_u) begin
        sum_mac = {ACC_W{1'b1}};
      end else begin
        sum_mac = sum_wrap;
      end
    end
`else
    sum_wrap = in_sum + prod_acc;
    sum_mac  = sum_wrap;
`endif
  end

  // Output stage next values: pass-through registers and partial sum.
  always_comb begin
    out_act_d        = in_act;
    out_act_vld_d    = in_act_vld;
    out_weight_d     = in_weight;
    out_weight_vld_d = in_weight_vld;
    out_sum_vld_d    = in_act_vld;
    if (in_act_vld) begin
      out_sum_d = sum_mac;
    end else begin
      out_sum_d = in_sum;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_q[i] <= {D_W{1'b0}};
      end
      act_ptr_q        <= {AW{1'b0}};
      wr_ptr_q         <= {AW{1'b0}};
      pend_q           <= {PW{1'b0}};
      err_q            <= 1'b0;
      out_act_q        <= {D_W{1'b0}};
      out_act_vld_q    <= 1'b0;
      out_weight_q     <= {D_W{1'b0}};
      out_weight_vld_q <= 1'b0;
      out_sum_q        <= {ACC_W{1'b0}};
      out_sum_vld_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_q[i] <= bank_d[i];
      end
      act_ptr_q        <= act_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      pend_q           <= pend_d;
      err_q            <= err_d;
      out_act_q        <= out_act_d;
      out_act_vld_q    <= out_act_vld_d;
      out_weight_q     <= out_weight_d;
      out_weight_vld_q <= out_weight_vld_d;
      out_sum_q        <= out_sum_d;
      out_sum_vld_q    <= out_sum_vld_d;
    end
  end

  assign out_act        = out_act_q;
  assign out_act_vld    = out_act_vld_q;
  assign out_weight     = out_weight_q;
  assign out_weight_vld = out_weight_vld_q;
  assign out_sum        = out_sum_q;
  assign out_sum_vld    = out_sum_vld_q;
  assign w_pending      = pend_q;
  assign err            = err_q;

endmodule

// File: tb/tb_pe_ws_mbank.sv
// Directed bench for pe_ws_mbank (D_W=8, ACC_W=20, NUM_BANKS=2). Each table row
// is one clock cycle of inputs plus the outputs expected right after that edge.
// With NUM_BANKS=2 a concurrent load+swap while one shadow is pending drops the
// load (pre-edge full check) and the swap lowers w_pending to 0.
module tb_pe_ws_mbank;

  localparam int D_W   = 8;
  localparam int ACC_W = 20;
  localparam int NB    = 2;
  localparam int PW    = 2 + $clog2(NB);

  logic             clk;
  logic             rst;
  logic             signed_mode;
  logic [D_W-1:0]   in_act;
  logic             in_act_vld;
  logic [D_W-1:0]   in_weight;
  logic             in_weight_vld;
  logic             w_swap;
  logic [ACC_W-1:0] in_sum;
  logic [D_W-1:0]   out_act;
  logic             out_act_vld;
  logic [D_W-1:0]   out_weight;
  logic             out_weight_vld;
  logic [ACC_W-1:0] out_sum;
  logic             out_sum_vld;
  logic [PW-1:0]    w_pending;
  logic             err;

  pe_ws_mbank #(.D_W(D_W), .ACC_W(ACC_W), .NUM_BANKS(NB)) dut (
    .clk(clk), .rst(rst), .signed_mode(signed_mode),
    .in_act(in_act), .in_act_vld(in_act_vld),
    .in_weight(in_weight), .in_weight_vld(in_weight_vld),
    .w_swap(w_swap), .in_sum(in_sum),
    .out_act(out_act), .out_act_vld(out_act_vld),
    .out_weight(out_weight), .out_weight_vld(out_weight_vld),
    .out_sum(out_sum), .out_sum_vld(out_sum_vld),
    .w_pending(w_pending), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             sm;
    logic [D_W-1:0]   act;
    logic             av;
    logic [D_W-1:0]   w;
    logic             wv;
    logic             sw;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] esum;   // expected out_sum, wrap build
    logic [ACC_W-1:0] esat;   // expected out_sum, saturating build
    logic [PW-1:0]    epend;
    logic             eerr;
  } vec_t;

  vec_t tbl[$];
  int   total  = 0;
  int   passed = 0;

  function automatic vec_t mk(input logic r, input logic sm, input logic [D_W-1:0] a,
                              input logic av, input logic [D_W-1:0] w, input logic wv,
                              input logic sw, input logic [ACC_W-1:0] s,
                              input logic [ACC_W-1:0] es, input logic [PW-1:0] ep,
                              input logic ee);
    vec_t v;
    v.rst = r; v.sm = sm; v.act = a; v.av = av; v.w = w; v.wv = wv; v.sw = sw;
    v.sum = s; v.esum = es; v.esat = es; v.epend = ep; v.eerr = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end else begin
      passed++;
    end
  endtask

  initial begin
    vec_t v;
    logic [ACC_W-1:0] exp_sum;
    logic [D_W-1:0]   prev_a;
    logic [D_W-1:0]   prev_w;
    logic [D_W-1:0]   ra;
    logic [D_W-1:0]   rw;
    logic [ACC_W-1:0] rs;

    //          rst sm act    av w      wv sw sum          esum         pend err
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 20'h00000, 20'h00000, 3'd0, 0)); // 0 reset
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h03, 1, 0, 20'h00000, 20'h00000, 3'd1, 0)); // 1 load 3
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 20'h00000, 20'h00000, 3'd0, 0)); // 2 swap
    tbl.push_back(mk(0, 0, 8'h04, 1, 8'h00, 0, 0, 20'd10,    20'd22,    3'd0, 0)); // 3 10+4*3
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h05, 1, 0, 20'h00000, 20'h00000, 3'd1, 0)); // 4 load 5
    tbl.push_back(mk(0, 0, 8'h02, 1, 8'h00, 0, 1, 20'd100,   20'd106,   3'd0, 0)); // 5 swap: old w=3
    tbl.push_back(mk(0, 0, 8'h02, 1, 8'h00, 0, 0, 20'd100,   20'd110,   3'd0, 0)); // 6 new w=5
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'hFD, 1, 0, 20'h00000, 20'h00000, 3'd1, 0)); // 7 load -3
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 20'h00000, 20'h00000, 3'd0, 0)); // 8 swap
    tbl.push_back(mk(0, 1, 8'h80, 1, 8'h00, 0, 0, 20'h00000, 20'd384,   3'd0, 0)); // 9 -128*-3
    tbl.push_back(mk(0, 0, 8'h80, 1, 8'h00, 0, 0, 20'h00000, 20'd32384, 3'd0, 0)); // 10 128*253
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 20'h12345, 20'h12345, 3'd0, 0)); // 11 pass sum
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h07, 1, 0, 20'h00000, 20'h00000, 3'd1, 0)); // 12 load 7
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h09, 1, 0, 20'h00000, 20'h00000, 3'd1, 1)); // 13 full: drop
    tbl.push_back(mk(0, 1, 8'h01, 1, 8'h00, 0, 0, 20'h00000, 20'hFFFFD, 3'd1, 1)); // 14 still w=-3
    tbl.push_back(mk(0, 1, 8'h01, 1, 8'h11, 1, 1, 20'h00000, 20'hFFFFD, 3'd0, 1)); // 15 full load+swap
    tbl.push_back(mk(0, 0, 8'h01, 1, 8'h00, 0, 0, 20'd5,     20'd12,    3'd0, 1)); // 16 w=7
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 20'h00000, 20'h00000, 3'd0, 0)); // 17 reset
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h06, 1, 0, 20'h00000, 20'h00000, 3'd1, 0)); // 18 load 6
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 20'h00000, 20'h00000, 3'd0, 0)); // 19 swap
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 20'h00000, 20'h00000, 3'd0, 1)); // 20 empty swap
    tbl.push_back(mk(0, 0, 8'h02, 1, 8'h00, 0, 0, 20'h00000, 20'd12,    3'd0, 1)); // 21 w=6 kept
    tbl.push_back(mk(0, 0, 8'h01, 1, 8'h0A, 1, 1, 20'h00000, 20'd6,     3'd1, 1)); // 22 load+empty swap
    tbl.push_back(mk(0, 0, 8'h01, 1, 8'h00, 0, 0, 20'h00000, 20'd6,     3'd1, 1)); // 23 w=6 kept
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 20'h00000, 20'h00000, 3'd0, 0)); // 24 reset
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h01, 1, 0, 20'h00000, 20'h00000, 3'd1, 0)); // 25 load 1
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 20'h00000, 20'h00000, 3'd0, 0)); // 26 swap
    tbl.push_back(mk(0, 1, 8'h01, 1, 8'h00, 0, 0, 20'h7FFFF, 20'h80000, 3'd0, 0)); // 27 +ovf
    tbl[27].esat = 20'h7FFFF;
    tbl.push_back(mk(0, 0, 8'h01, 1, 8'h00, 0, 0, 20'hFFFFF, 20'h00000, 3'd0, 0)); // 28 unsigned ovf
    tbl[28].esat = 20'hFFFFF;
    tbl.push_back(mk(0, 1, 8'hFF, 1, 8'h00, 0, 0, 20'h80000, 20'h7FFFF, 3'd0, 0)); // 29 -ovf
    tbl[29].esat = 20'h80000;
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 20'hFFFFF, 20'hFFFFF, 3'd0, 0)); // 30 pass, no clamp
    tbl.push_back(mk(1, 0, 8'h03, 1, 8'h55, 1, 1, 20'h00123, 20'h00000, 3'd0, 0)); // 31 rst mid-load
    tbl.push_back(mk(0, 0, 8'h01, 1, 8'h00, 0, 0, 20'h00000, 20'h00000, 3'd0, 0)); // 32 banks cleared
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 20'h00000, 20'h00000, 3'd0, 1)); // 33 empty after rst

    rst = 1'b1; signed_mode = 1'b0; in_act = '0; in_act_vld = 1'b0;
    in_weight = '0; in_weight_vld = 1'b0; w_swap = 1'b0; in_sum = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      rst = v.rst; signed_mode = v.sm; in_act = v.act; in_act_vld = v.av;
      in_weight = v.w; in_weight_vld = v.wv; w_swap = v.sw; in_sum = v.sum;
      @(posedge clk);
      #1;
`ifdef PE_SAT_EN
      exp_sum = v.esat;
`else
      exp_sum = v.esum;
`endif
      chk($sformatf("r%0d out_sum", i), 32'(out_sum), 32'(exp_sum));
      chk($sformatf("r%0d out_sum_vld", i), 32'(out_sum_vld), 32'(v.rst ? 1'b0 : v.av));
      chk($sformatf("r%0d out_act", i), 32'(out_act), 32'(v.rst ? 8'h00 : v.act));
      chk($sformatf("r%0d out_act_vld", i), 32'(out_act_vld), 32'(v.rst ? 1'b0 : v.av));
      chk($sformatf("r%0d out_weight", i), 32'(out_weight), 32'(v.rst ? 8'h00 : v.w));
      chk($sformatf("r%0d out_weight_vld", i), 32'(out_weight_vld), 32'(v.rst ? 1'b0 : v.wv));
      chk($sformatf("r%0d w_pending", i), 32'(w_pending), 32'(v.epend));
      chk($sformatf("r%0d err", i), 32'(err), 32'(v.eerr));
    end

    // Pass-through latency: outputs hold the previous cycle's inputs until the
    // next edge, then take the new ones.
    rst = 1'b0; in_act_vld = 1'b0; in_weight_vld = 1'b0; w_swap = 1'b0;
    prev_a = out_act;
    prev_w = out_weight;
    for (int k = 0; k < 6; k++) begin
      ra = D_W'($urandom);
      rw = D_W'($urandom);
      rs = ACC_W'($urandom);
      in_act = ra; in_weight = rw; in_sum = rs;
      #1;
      chk($sformatf("lat%0d out_act hold", k), 32'(out_act), 32'(prev_a));
      chk($sformatf("lat%0d out_weight hold", k), 32'(out_weight), 32'(prev_w));
      @(posedge clk);
      #1;
      chk($sformatf("lat%0d out_act", k), 32'(out_act), 32'(ra));
      chk($sformatf("lat%0d out_weight", k), 32'(out_weight), 32'(rw));
      chk($sformatf("lat%0d out_sum pass", k), 32'(out_sum), 32'(rs));
      prev_a = ra;
      prev_w = rw;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
